// File: rtl/apb_sram_arbiter.sv
// apb_sram_arbiter: shares one APB SRAM slave between the instruction-fetch
// master (m0) and the load/store master (m1). One request is granted at a
// time and replayed downstream as a clean SETUP + ACCESS pair.
//
// Handshake: a master raises mX_psel with stable paddr/pdata/pstb/pwrite and
// holds it until it sees mX_pready=1 at a rising edge; that edge ends the
// transfer. mX_perr and mX_prdata are meaningful only while mX_pready=1.
// Downstream, the slave completes an ACCESS cycle by driving s_pready=1.
module apb_sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic [DATA_WIDTH-1:0] m0_pdata,
    input  logic [3:0]            m0_pstb,
    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    output logic [DATA_WIDTH-1:0] m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_perr,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic [DATA_WIDTH-1:0] m1_pdata,
    input  logic [3:0]            m1_pstb,
    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    output logic [DATA_WIDTH-1:0] m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_perr,
    output logic [ADDR_WIDTH-1:0] s_paddr,
    output logic [DATA_WIDTH-1:0] s_pdata,
    output logic [3:0]            s_pstb,
    output logic                  s_pwrite,
    output logic                  s_psel,
    output logic                  s_penable,
    input  logic [DATA_WIDTH-1:0] s_prdata,
    input  logic                  s_pready,
    input  logic                  s_perr,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Watchdog counts ACCESS cycles already elapsed, so the TIMEOUT-th ACCESS
    // cycle is the one where the count reads TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic            grant;       // 0: m0 owns the slave, 1: m1
    logic            last_grant;
    logic [WD_W-1:0] wd;

    logic timeout_hit;
    logic done;
    logic idle_pick;
    logic nxt;
    logic nxt_req;

    // Master-side penable carries no information: the arbiter sequences its own phases.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // Completion detection: slave ready, or the watchdog reaching its limit.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && (wd == WD_LAST);
        done        = (state == ACCESS) && (s_pready || timeout_hit);
    end

    // Next winner: from IDLE either master may win; on completion only the
    // other master may be taken, the served one's psel still belongs to its finished transfer.
    always_comb begin
        if (m0_psel && m1_psel) begin
            idle_pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else begin
            idle_pick = m1_psel;
        end
        nxt     = (state == IDLE) ? idle_pick : ~grant;
        nxt_req = (state == IDLE) ? (m0_psel | m1_psel) : (grant ? m0_psel : m1_psel);
    end

    // Arbitration FSM with registered downstream request and phase controls.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wd         <= '0;
            s_paddr    <= '0;
            s_pdata    <= '0;
            s_pstb     <= '0;
            s_pwrite   <= 1'b0;
            s_psel     <= 1'b0;
            s_penable  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (nxt_req) begin
                        grant      <= nxt;
                        last_grant <= nxt;
                        s_paddr    <= nxt ? m1_paddr  : m0_paddr;
                        s_pdata    <= nxt ? m1_pdata  : m0_pdata;
                        s_pstb     <= nxt ? m1_pstb   : m0_pstb;
                        s_pwrite   <= nxt ? m1_pwrite : m0_pwrite;
                        wd         <= '0;
                        s_psel     <= 1'b1;
                        s_penable  <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    s_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        if (nxt_req) begin
                            grant      <= nxt;
                            last_grant <= nxt;
                            s_paddr    <= nxt ? m1_paddr  : m0_paddr;
                            s_pdata    <= nxt ? m1_pdata  : m0_pdata;
                            s_pstb     <= nxt ? m1_pstb   : m0_pstb;
                            s_pwrite   <= nxt ? m1_pwrite : m0_pwrite;
                            wd         <= '0;
                            s_penable  <= 1'b0;
                            state      <= SETUP;
                        end else begin
                            s_psel    <= 1'b0;
                            s_penable <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    s_psel    <= 1'b0;
                    s_penable <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Response steering: only the granted master sees the completion.
    always_comb begin
        m0_pready = done & ~grant;
        m1_pready = done & grant;
        m0_perr   = m0_pready & (s_perr | timeout_hit);
        m1_perr   = m1_pready & (s_perr | timeout_hit);
        m0_prdata = m0_pready ? s_prdata : '0;
        m1_prdata = m1_pready ? s_prdata : '0;
    end

    assign dbg_state = state;

endmodule
